// File: rtl/rx_dll_seq_ack_if.sv
// TLP ingress, TLP egress and DLLP egress handshake bundle for the
// receive-side data link layer stage.
interface rx_dll_seq_ack_if #(
  parameter int DATA_W = 1024
);
  logic [DATA_W-1:0] tlp_data_in;
  logic [11:0]       tlp_seq_in;
  logic              tlp_lcrc_ok;
  logic              tlp_data_in_valid;
  logic              tlp_data_in_ready;
  logic [DATA_W-1:0] tlp_data_out;
  logic              tlp_data_out_valid;
  logic              tlp_data_out_ready;
  logic [31:0]       dllp;
  logic              dllp_valid;
  logic              dllp_ready;

  // Link layer block side
  modport slave (
    input  tlp_data_in, tlp_seq_in, tlp_lcrc_ok, tlp_data_in_valid,
    input  tlp_data_out_ready, dllp_ready,
    output tlp_data_in_ready, tlp_data_out, tlp_data_out_valid,
    output dllp, dllp_valid
  );

  // Environment side (RX datapath, transaction layer, DLLP sink)
  modport master (
    output tlp_data_in, tlp_seq_in, tlp_lcrc_ok, tlp_data_in_valid,
    output tlp_data_out_ready, dllp_ready,
    input  tlp_data_in_ready, tlp_data_out, tlp_data_out_valid,
    input  dllp, dllp_valid
  );
endinterface

// File: rtl/rx_dll_seq_ack.sv
// Receive-side DLL stage: LCRC/sequence check, in-order forward FIFO and
// ACK/NAK DLLP generation with coalescing and timeout.
module rx_dll_seq_ack #(
  parameter int DATA_W       = 1024,
  parameter int DEPTH        = 4,
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               reset,
  rx_dll_seq_ack_if.slave    bus,
  output logic [11:0]        next_rcv_seq_o,
  output logic [15:0]        err_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [7:0]       COAL_LIM = 8'(ACK_COALESCE);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [11:0]      nrs_q, nrs_d;
  logic [15:0]      err_q, err_d;
  logic             nak_sched_q, nak_sched_d;
  logic             nak_req_q, nak_req_d;
  logic             dup_req_q, dup_req_d;
  logic [7:0]       pend_q, pend_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  state_t           state_q, state_d;
  logic [31:0]      dllp_q, dllp_d;

  logic        in_ready, out_valid, accept, push, pop;
  logic        is_good, is_dup, good_acc, dup_acc, bad_acc, ack_req;
  logic [11:0] seq_diff;

  assign in_ready  = !reset && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = bus.tlp_data_in_valid && in_ready;

  // Duplicate window: sequence numbers up to 2048 behind NEXT_RCV_SEQ.
  assign seq_diff = nrs_q - bus.tlp_seq_in;
  assign is_good  = bus.tlp_lcrc_ok && (bus.tlp_seq_in == nrs_q);
  assign is_dup   = bus.tlp_lcrc_ok && (seq_diff != 12'd0) && (seq_diff <= 12'd2048);
  assign good_acc = accept && is_good;
  assign dup_acc  = accept && is_dup;
  assign bad_acc  = accept && !is_good && !is_dup;

  assign push = good_acc;
  assign pop  = out_valid && bus.tlp_data_out_ready;

  assign ack_req = (pend_q >= COAL_LIM) || ((pend_q != 8'd0) && (tmr_q == TMR_LAST)) || dup_req_q;

  assign bus.tlp_data_in_ready  = in_ready;
  assign bus.tlp_data_out_valid = out_valid;
  assign bus.tlp_data_out       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.dllp_valid         = (state_q == S_HOLD);
  assign bus.dllp               = (state_q == S_HOLD) ? dllp_q : 32'd0;
  assign next_rcv_seq_o         = nrs_q;
  assign err_cnt_o              = err_q;

  // Forward buffer storage; written only on a GOOD accept, never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tlp_data_in;
  end

  // Forward buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Sequence tracking, request bookkeeping and DLLP state machine.
  always_comb begin
    nrs_d       = nrs_q;
    err_d       = err_q;
    nak_sched_d = nak_sched_q;
    nak_req_d   = nak_req_q;
    dup_req_d   = dup_req_q;
    pend_d      = pend_q;
    tmr_d       = '0;
    state_d     = state_q;
    dllp_d      = dllp_q;

    // Timer holds at its last value so a blocked timeout request survives HOLD.
    if (pend_q != 8'd0) tmr_d = (tmr_q == TMR_LAST) ? tmr_q : tmr_q + 1'b1;

    if (good_acc) begin
      nrs_d       = nrs_q + 12'd1;
      nak_sched_d = 1'b0;
      pend_d      = sat_inc8(pend_q);
    end

    case (state_q)
      S_IDLE: begin
        if (nak_req_q) begin
          dllp_d    = {8'h10, 12'h000, nrs_d - 12'd1};
          nak_req_d = 1'b0;
          state_d   = S_HOLD;
        end else if (ack_req) begin
          dllp_d    = {8'h00, 12'h000, nrs_d - 12'd1};
          pend_d    = good_acc ? 8'd1 : 8'd0;
          tmr_d     = '0;
          dup_req_d = 1'b0;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.dllp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // New requests arriving in a latch cycle are kept for the next DLLP.
    if (bad_acc) begin
      err_d = sat_inc16(err_q);
      if (!nak_sched_q) begin
        nak_sched_d = 1'b1;
        nak_req_d   = 1'b1;
      end
    end
    if (dup_acc) dup_req_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      nrs_q       <= '0;
      err_q       <= '0;
      nak_sched_q <= 1'b0;
      nak_req_q   <= 1'b0;
      dup_req_q   <= 1'b0;
      pend_q      <= '0;
      tmr_q       <= '0;
      state_q     <= S_IDLE;
    end else begin
      nrs_q       <= nrs_d;
      err_q       <= err_d;
      nak_sched_q <= nak_sched_d;
      nak_req_q   <= nak_req_d;
      dup_req_q   <= dup_req_d;
      pend_q      <= pend_d;
      tmr_q       <= tmr_d;
      state_q     <= state_d;
    end
  end

  // DLLP payload register; only observable while in HOLD.
  always_ff @(posedge clk) begin
    dllp_q <= dllp_d;
  end

endmodule
